// File: rtl/branch_resolver_if.sv
// Branch request / redirect bundle between the EX stage and the branch resolver.
// The master side issues requests; the slave side resolves them and drives the redirect, flush and statistics.
interface branch_resolver_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             br_valid;
    logic             br_ready;
    logic [1:0]       br_op;
    logic             zero;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] imm;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             flush;
    logic             taken;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output br_valid, br_op, zero, pc_plus4, imm,
        input  br_ready, redirect_valid, redirect_pc, flush, taken, branch_cnt, taken_cnt
    );

    modport slave (
        input  br_valid, br_op, zero, pc_plus4, imm,
        output br_ready, redirect_valid, redirect_pc, flush, taken, branch_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_resolver.sv
// Resolves BEQ/BNE/J requests from the ALU zero flag, issues a one-cycle PC redirect plus a
// multi-cycle flush on taken branches, and keeps saturating branch/taken statistics.
module branch_resolver #(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    branch_resolver_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EVAL    = 2'd1;
    localparam logic [1:0] S_RESOLVE = 2'd2;
    localparam logic [1:0] S_FLUSH   = 2'd3;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_BEQ = 2'b01;
    localparam logic [1:0] OP_BNE = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic             r_zero;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_imm;
    logic             r_tk_pend;
    logic [WIDTH-1:0] r_tgt_pend;
    logic             r_taken;
    logic             r_redirect_valid;
    logic [WIDTH-1:0] r_redirect_pc;
    logic             r_flush;
    logic [FW-1:0]    r_flush_cnt;

    logic             w_taken;
    logic [WIDTH-1:0] w_target;
    logic [1:0]       w_inc;

    always_comb begin
        w_taken = 1'b0;
        case (r_op)
            OP_BEQ:  w_taken = r_zero;
            OP_BNE:  w_taken = ~r_zero;
            OP_J:    w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    // The jump keeps the upper PC region; conditional targets wrap modulo 2^WIDTH.
    assign w_target = (r_op == OP_J) ? {r_pc[WIDTH-1:28], r_imm[25:0], 2'b00}
                                     : r_pc + (r_imm << 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_op             <= OP_NOP;
            r_zero           <= 1'b0;
            r_pc             <= '0;
            r_imm            <= '0;
            r_tk_pend        <= 1'b0;
            r_tgt_pend       <= '0;
            r_taken          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
            r_flush_cnt      <= '0;
        end else begin
            r_redirect_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.br_valid) begin
                        r_op    <= bus.br_op;
                        r_zero  <= bus.zero;
                        r_pc    <= bus.pc_plus4;
                        r_imm   <= bus.imm;
                        r_state <= S_EVAL;
                    end
                end
                // Decision and target are registered one cycle ahead so the adder stays off the output path.
                S_EVAL: begin
                    r_tk_pend  <= w_taken;
                    r_tgt_pend <= w_target;
                    r_state    <= S_RESOLVE;
                end
                S_RESOLVE: begin
                    r_taken <= r_tk_pend;
                    if (r_tk_pend) begin
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= r_tgt_pend;
                        r_flush          <= 1'b1;
                        r_flush_cnt      <= FW'(FLUSH_CYCLES - 1);
                        r_state          <= S_FLUSH;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    if (r_flush_cnt == '0) begin
                        r_flush <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - FW'(1);
                    end
                end
            endcase
        end
    end

    assign w_inc[0] = (r_state == S_RESOLVE) && (r_op != OP_NOP);
    assign w_inc[1] = (r_state == S_RESOLVE) && r_tk_pend;

    // Index 0 counts resolved branches, index 1 counts taken ones; both stick at all-ones.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_inc[gi] && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign bus.br_ready       = (r_state == S_IDLE);
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.flush          = r_flush;
    assign bus.taken          = r_taken;
    assign bus.branch_cnt     = g_cnt[0].r_cnt;
    assign bus.taken_cnt      = g_cnt[1].r_cnt;
endmodule
